// File: rtl/wr_pps_timekeeper.sv
// PPS qualifier and local (seconds, cycle) timekeeper fed by the WR core timing outputs.
// Holdover free-run is built only when WR_PPS_TIMEKEEPER_HOLDOVER_EN is defined.
module wr_pps_timekeeper #(
  parameter int unsigned CLKS_PER_SEC  = 62500000,
  parameter int unsigned TOL           = 2,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int unsigned HOLDOVER_SECS = 8,
  parameter int unsigned TAI_W         = 10
) (
  input  logic             clk_sys_i,
  input  logic             rst_i,
  input  logic             pps_i,
  input  logic [TAI_W-1:0] tm_tai_i,
  output logic             pps_o,
  output logic [TAI_W-1:0] sec_o,
  output logic [31:0]      cycles_o,
  output logic             locked_o,
  output logic             time_valid_o,
  output logic [1:0]       state_o,
  output logic [15:0]      err_cnt_o,
  output logic [15:0]      missed_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_t;

  localparam logic [31:0] P_MIN  = 32'(CLKS_PER_SEC - TOL);
  localparam logic [31:0] P_MAX  = 32'(CLKS_PER_SEC + TOL);
  localparam logic [31:0] TMO    = 32'(CLKS_PER_SEC + TOL + 1);
  localparam logic [31:0] LAST   = 32'(CLKS_PER_SEC - 1);
  localparam logic [31:0] TOL_C  = 32'(TOL);
  localparam logic [7:0]  LOCK_C = 8'(LOCK_COUNT);
  localparam logic [15:0] HOLD_C = 16'(HOLDOVER_SECS);

  state_t           state, state_nxt;
  logic             pps_s, pps_d;
  logic [TAI_W-1:0] tai_s;
  logic [31:0]      ival, ival_nxt;
  logic [7:0]       good_cnt, good_nxt;
  logic [15:0]      wrap_cnt, wrap_nxt;
  logic [31:0]      cyc_nxt, run_cyc;
  logic [TAI_W-1:0] sec_nxt, run_sec;
  logic [15:0]      run_wrap;
  logic             pps_nxt, err_inc, miss_inc;
  logic             rise, period_ok, timeout, wrap;

  assign state_o = state;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    rise      = pps_s & ~pps_d;
    period_ok = (ival >= P_MIN) && (ival <= P_MAX);
    timeout   = (ival >= TMO);
    wrap      = (cycles_o == LAST);

    // Free-running local time; wrap_cnt counts seconds since the last alignment.
    run_cyc  = wrap ? 32'd0 : cycles_o + 32'd1;
    run_sec  = wrap ? sec_o + TAI_W'(1) : sec_o;
    run_wrap = (wrap && (wrap_cnt != HOLD_C)) ? wrap_cnt + 16'd1 : wrap_cnt;

    state_nxt = state;
    good_nxt  = good_cnt;
    wrap_nxt  = wrap_cnt;
    cyc_nxt   = cycles_o;
    sec_nxt   = sec_o;
    pps_nxt   = 1'b0;
    err_inc   = 1'b0;
    miss_inc  = 1'b0;
    ival_nxt  = rise ? 32'd1 : (timeout ? ival : ival + 32'd1);

    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_ACQUIRE;
          good_nxt  = 8'd0;
        end
      end

      ST_ACQUIRE: begin
        if (rise) begin
          if (period_ok) begin
            good_nxt = good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_C) begin
              state_nxt = ST_LOCKED;
              cyc_nxt   = 32'd0;
              sec_nxt   = tai_s;
              wrap_nxt  = 16'd0;
              pps_nxt   = 1'b1;
            end
          end else begin
            err_inc  = 1'b1;
            good_nxt = 8'd0;
          end
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_LOCKED: begin
        if (rise) begin
          if (period_ok) begin
            // Realign; a wrap pulse up to TOL cycles earlier already marked this second.
            cyc_nxt  = 32'd0;
            sec_nxt  = tai_s;
            wrap_nxt = 16'd0;
            pps_nxt  = wrap || (cycles_o >= TOL_C);
          end else begin
            state_nxt = ST_ACQUIRE;
            err_inc   = 1'b1;
            good_nxt  = 8'd1;
          end
        end else if (timeout) begin
          miss_inc = 1'b1;
`ifdef WR_PPS_TIMEKEEPER_HOLDOVER_EN
          state_nxt = ST_HOLDOVER;
          cyc_nxt   = run_cyc;
          sec_nxt   = run_sec;
          wrap_nxt  = run_wrap;
          pps_nxt   = wrap;
`else
          state_nxt = ST_IDLE;
`endif
        end else begin
          cyc_nxt  = run_cyc;
          sec_nxt  = run_sec;
          wrap_nxt = run_wrap;
          pps_nxt  = wrap;
        end
      end

`ifdef WR_PPS_TIMEKEEPER_HOLDOVER_EN
      ST_HOLDOVER: begin
        if (rise) begin
          state_nxt = ST_ACQUIRE;
          good_nxt  = 8'd0;
        end else begin
          cyc_nxt  = run_cyc;
          sec_nxt  = run_sec;
          wrap_nxt = run_wrap;
          pps_nxt  = wrap;
          if (wrap) begin
            // The first wrap after the last pulse was already covered by the timeout miss.
            miss_inc = (wrap_cnt != 16'd0);
            if (run_wrap >= HOLD_C) state_nxt = ST_IDLE;
          end
        end
      end
`endif

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      pps_s        <= 1'b0;
      pps_d        <= 1'b0;
      tai_s        <= '0;
      ival         <= 32'd0;
      good_cnt     <= 8'd0;
      wrap_cnt     <= 16'd0;
      pps_o        <= 1'b0;
      sec_o        <= '0;
      cycles_o     <= 32'd0;
      locked_o     <= 1'b0;
      time_valid_o <= 1'b0;
      err_cnt_o    <= 16'd0;
      missed_cnt_o <= 16'd0;
    end else begin
      state        <= state_nxt;
      pps_s        <= pps_i;
      pps_d        <= pps_s;
      tai_s        <= tm_tai_i;
      ival         <= ival_nxt;
      good_cnt     <= good_nxt;
      wrap_cnt     <= wrap_nxt;
      pps_o        <= pps_nxt;
      sec_o        <= sec_nxt;
      cycles_o     <= cyc_nxt;
      locked_o     <= (state_nxt == ST_LOCKED);
      time_valid_o <= (state_nxt == ST_LOCKED) || (state_nxt == ST_HOLDOVER);
      if (err_inc && (err_cnt_o != 16'hFFFF))     err_cnt_o    <= err_cnt_o + 16'd1;
      if (miss_inc && (missed_cnt_o != 16'hFFFF)) missed_cnt_o <= missed_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_wr_pps_timekeeper.sv
// Bench for wr_pps_timekeeper: a timeline model (absolute edge numbers, epochs) is
// compared every cycle, plus literal checkpoints at key rises and outage edges.
module tb_wr_pps_timekeeper;
  localparam int CLKS  = 100;
  localparam int TOL   = 2;
  localparam int LOCK  = 3;
  localparam int HOLD  = 4;
  localparam int TAI_W = 10;
  localparam int TMO   = CLKS + TOL + 1;

  logic             clk_sys = 1'b0;
  logic             rst     = 1'b1;
  logic             pps     = 1'b0;
  logic [TAI_W-1:0] tai     = '0;
  logic             pps_o, locked_o, time_valid_o;
  logic [TAI_W-1:0] sec_o;
  logic [31:0]      cycles_o;
  logic [1:0]       state_o;
  logic [15:0]      err_cnt_o, missed_cnt_o;

  wr_pps_timekeeper #(
    .CLKS_PER_SEC(CLKS), .TOL(TOL), .LOCK_COUNT(LOCK),
    .HOLDOVER_SECS(HOLD), .TAI_W(TAI_W)
  ) dut (
    .clk_sys_i(clk_sys), .rst_i(rst), .pps_i(pps), .tm_tai_i(tai),
    .pps_o(pps_o), .sec_o(sec_o), .cycles_o(cycles_o), .locked_o(locked_o),
    .time_valid_o(time_valid_o), .state_o(state_o),
    .err_cnt_o(err_cnt_o), .missed_cnt_o(missed_cnt_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int rise_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  function automatic bit good_period(input int p);
    int d;
    d = (p > CLKS) ? p - CLKS : CLKS - p;
    return d <= TOL;
  endfunction

  // Model state: absolute edge of last rise, alignment epoch and its seconds value.
  int m_state, m_good, m_err, m_missed, m_last, m_epoch, m_secb, m_lastpulse;
  int ex_pps, ex_cyc, ex_sec;
  bit p1, p2;
  int tai1;

  always @(posedge clk_sys) begin
    int k, el, adv_cyc, adv_sec, tai_now;
    bit rise, valid, wrap, tmo;
    edge_n++;
    k = edge_n;
    if (rst) begin
      m_state = 0; m_good = 0; m_err = 0; m_missed = 0;
      m_last = 0; m_epoch = 0; m_secb = 0; m_lastpulse = 0;
      ex_pps = 0; ex_cyc = 0; ex_sec = 0;
      p1 = 0; p2 = 0; tai1 = 0;
    end else begin
      rise    = p1 && !p2;
      tai_now = tai1;
      p2 = p1; p1 = pps; tai1 = int'(tai);
      ex_pps  = 0;
      valid   = (m_state == 2) || (m_state == 3);
      el      = k - m_epoch;
      wrap    = valid && (el > 0) && (el % CLKS == 0);
      adv_cyc = el % CLKS;
      adv_sec = (m_secb + el / CLKS) % (1 << TAI_W);
      tmo     = (k - m_last) >= TMO;
      case (m_state)
        0: if (rise) begin m_state = 1; m_good = 0; m_last = k; end
        1: begin
          if (rise) begin
            if (good_period(k - m_last)) begin
              m_good++;
              if (m_good >= LOCK) begin
                m_state = 2; m_epoch = k; m_secb = tai_now;
                ex_cyc = 0; ex_sec = tai_now; ex_pps = 1; m_lastpulse = k;
              end
            end else begin
              if (m_err < 65535) m_err++;
              m_good = 0;
            end
            m_last = k;
          end else if (tmo) m_state = 0;
        end
        2: begin
          if (rise) begin
            if (good_period(k - m_last)) begin
              if (wrap || (k - m_lastpulse > TOL)) begin ex_pps = 1; m_lastpulse = k; end
              m_epoch = k; m_secb = tai_now; ex_cyc = 0; ex_sec = tai_now;
            end else begin
              m_state = 1; m_good = 1;
              if (m_err < 65535) m_err++;
            end
            m_last = k;
          end else if (tmo) begin
            if (m_missed < 65535) m_missed++;
`ifdef WR_PPS_TIMEKEEPER_HOLDOVER_EN
            m_state = 3; ex_cyc = adv_cyc; ex_sec = adv_sec;
            if (wrap) begin ex_pps = 1; m_lastpulse = k; end
`else
            m_state = 0;
`endif
          end else begin
            ex_cyc = adv_cyc; ex_sec = adv_sec;
            if (wrap) begin ex_pps = 1; m_lastpulse = k; end
          end
        end
        default: begin
          if (rise) begin m_state = 1; m_good = 0; m_last = k; end
          else begin
            ex_cyc = adv_cyc; ex_sec = adv_sec;
            if (wrap) begin
              ex_pps = 1; m_lastpulse = k;
              if (el / CLKS >= 2 && m_missed < 65535) m_missed++;
              if (el / CLKS >= HOLD) m_state = 0;
            end
          end
        end
      endcase
    end
    #1;
    check("pps_o", pps_o, ex_pps);
    check("cycles_o", cycles_o, ex_cyc);
    check("sec_o", sec_o, ex_sec);
    check("state_o", state_o, m_state);
    check("locked_o", locked_o, m_state == 2);
    check("time_valid_o", time_valid_o, (m_state == 2) || (m_state == 3));
    check("err_cnt_o", err_cnt_o, m_err);
    check("missed_cnt_o", missed_cnt_o, m_missed);
  end

  // One PPS rise (2 cycles high) followed by silence; the next send's rise lands gap cycles later.
  task automatic send(input int gap, input int t, input bit chk,
                      input int e_st, input int e_p, input int e_c, input int e_s);
    @(negedge clk_sys);
    pps = 1'b1;
    tai = t[TAI_W-1:0];
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    rise_edge = edge_n;
    if (chk) begin
      check("rise_state", state_o, e_st);
      check("rise_pps", pps_o, e_p);
      check("rise_cycles", cycles_o, e_c);
      check("rise_sec", sec_o, e_s);
    end
    for (int i = 2; i < gap; i++) begin
      @(negedge clk_sys);
      pps = 1'b0;
    end
  endtask

  task automatic at_edge(input int n);
    if (n > edge_n) repeat (n - edge_n) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, hold_cyc, hold_sec, miss_end;
`ifdef WR_PPS_TIMEKEEPER_HOLDOVER_EN
    hold_cyc = 0; hold_sec = 20; miss_end = 4;
`else
    hold_cyc = 2; hold_sec = 17; miss_end = 1;
`endif
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk_sys);
      pps = ~pps;
      tai = tai + 10'd3;
    end
    check("reset_state", state_o, 0);
    check("reset_pps", pps_o, 0);
    check("reset_sec", sec_o, 0);
    check("reset_cycles", cycles_o, 0);
    check("reset_valid", time_valid_o, 0);
    @(negedge clk_sys);
    rst = 1'b0; pps = 1'b0; tai = '0;
    repeat (4) @(negedge clk_sys);

    send(100, 5, 1, 1, 0, 0, 0);
    send(100, 6, 0, 0, 0, 0, 0);
    send(100, 7, 0, 0, 0, 0, 0);
    send(100, 8, 1, 2, 1, 0, 8);
    check("lock_locked", locked_o, 1);
    send(100, 9, 0, 0, 0, 0, 0);
    send(97, 10, 1, 2, 1, 0, 10);
    send(100, 11, 1, 1, 0, 96, 10);
    check("early_err", err_cnt_o, 1);
    check("early_locked", locked_o, 0);
    send(100, 12, 0, 0, 0, 0, 0);
    send(100, 13, 1, 2, 1, 0, 13);
    send(102, 14, 1, 2, 1, 0, 14);
    send(100, 15, 1, 2, 0, 0, 15);
    send(3, 16, 1, 2, 1, 0, 16);

    e = rise_edge;
    at_edge(e + 100);
    check("out_wrap_pps", pps_o, 1);
    check("out_wrap_sec", sec_o, 17);
    at_edge(e + 103);
`ifdef WR_PPS_TIMEKEEPER_HOLDOVER_EN
    check("ho_state", state_o, 3);
    check("ho_missed", missed_cnt_o, 1);
    check("ho_cycles", cycles_o, 3);
    at_edge(e + 200);
    check("ho_pps200", pps_o, 1);
    check("ho_missed200", missed_cnt_o, 2);
    check("ho_sec200", sec_o, 18);
    at_edge(e + 300);
    check("ho_missed300", missed_cnt_o, 3);
    at_edge(e + 400);
    check("ho_idle_state", state_o, 0);
    check("ho_idle_valid", time_valid_o, 0);
    check("ho_missed400", missed_cnt_o, 4);
    at_edge(e + 401);
    check("ho_no_pps", pps_o, 0);
`else
    check("nho_state", state_o, 0);
    check("nho_missed", missed_cnt_o, 1);
    check("nho_cycles", cycles_o, 2);
    at_edge(e + 200);
    check("nho_no_pps", pps_o, 0);
    check("nho_sec", sec_o, 17);
`endif

    send(3, 1, 1, 1, 0, hold_cyc, hold_sec);
    e = rise_edge;
    at_edge(e + 102);
    check("acq_wait_state", state_o, 1);
    at_edge(e + 103);
    check("acq_tmo_state", state_o, 0);
    check("acq_tmo_missed", missed_cnt_o, miss_end);

    send(100, 30, 0, 0, 0, 0, 0);
    send(100, 31, 0, 0, 0, 0, 0);
    send(100, 32, 0, 0, 0, 0, 0);
    send(50, 33, 1, 2, 1, 0, 33);
    @(negedge clk_sys);
    rst = 1'b1;
    #1;
    check("midrst_state", state_o, 0);
    check("midrst_sec", sec_o, 0);
    check("midrst_err", err_cnt_o, 0);
    check("midrst_missed", missed_cnt_o, 0);
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
